// File: rtl/key_event_scanner_if.sv
// ---------------------------------------------------------------------------
// key_event_scanner_if
//
// Event read-out bus between the key/encoder scanner and the SPI reply path.
//
//   evt_data   scanner -> reader  FIFO head event code
//   evt_valid  scanner -> reader  FIFO not empty
//   evt_count  scanner -> reader  FIFO occupancy
//   overflow   scanner -> reader  sticky "an event was dropped" flag
//   evt_rd     reader  -> scanner one-clk pop strobe
//   ovf_clr    reader  -> scanner clears overflow
//
// Modports: master = scanner side, slave = reader side.
// ---------------------------------------------------------------------------
interface key_event_scanner_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       evt_data;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic             evt_rd;
  logic             ovf_clr;

  modport master (
    output evt_data,
    output evt_valid,
    output evt_count,
    output overflow,
    input  evt_rd,
    input  ovf_clr
  );

  modport slave (
    input  evt_data,
    input  evt_valid,
    input  evt_count,
    input  overflow,
    output evt_rd,
    output ovf_clr
  );
endinterface

// File: rtl/key_event_scanner.sv
// ---------------------------------------------------------------------------
// key_event_scanner
//
// Scans NUM_KEYS discrete keys and NUM_ENC quadrature encoders, one channel
// per clock, whenever scan_tick arrives. Keys are debounced over consecutive
// scans; encoders are Gray-decoded and accumulated into quarter-step counts.
// Resulting 8-bit event codes go into a first-word-fall-through FIFO that
// the reader drains through evt_if.
//
// Event code: [7] 0=key 1=encoder, [6] key press / encoder CW, [5:0] index.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   scan_tick  one-clk pulse starting a scan (ignored while busy)
//   keys_n     raw keys, active-low, asynchronous
//   enc_a/b    encoder phases, asynchronous
//   evt_if     event FIFO read-out bus (master side)
//   busy       scan in progress
// ---------------------------------------------------------------------------
module key_event_scanner #(
  parameter int NUM_KEYS            = 32,
  parameter int NUM_ENC             = 4,
  parameter int DEBOUNCE_TICKS      = 4,
  parameter int ENC_STEPS_PER_EVENT = 4,
  parameter int FIFO_DEPTH          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scan_tick,
  input  logic [NUM_KEYS-1:0]       keys_n,
  input  logic [NUM_ENC-1:0]        enc_a,
  input  logic [NUM_ENC-1:0]        enc_b,
  key_event_scanner_if.master       evt_if,
  output logic                      busy
);

  localparam int NUM_CH = NUM_KEYS + NUM_ENC;
  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int KEY_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int ENC_W  = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [3:0]        DEB_LAST = 4'(DEBOUNCE_TICKS - 1);
  localparam logic signed [3:0] STEP_POS = 4'(ENC_STEPS_PER_EVENT);
  localparam logic signed [3:0] STEP_NEG = 4'(-ENC_STEPS_PER_EVENT);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  // Gray-code quarter-step decode: 00->01->11->10->00 is +1, reverse is -1,
  // no change or a double-bit jump is 0.
  function automatic logic signed [3:0] gray_step(input logic [1:0] prev,
                                                  input logic [1:0] cur);
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return 4'sd1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return -4'sd1;
      default:                            return 4'sd0;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Input synchronisers
  // -------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] keys_meta, keys_sync;
  logic [NUM_ENC-1:0]  enc_a_meta, enc_a_sync;
  logic [NUM_ENC-1:0]  enc_b_meta, enc_b_sync;

  // NOTE: sequential state is always written with non-blocking assignments
  // so every flop samples the pre-edge value of its source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_meta  <= '1;
      keys_sync  <= '1;
      enc_a_meta <= '0;
      enc_a_sync <= '0;
      enc_b_meta <= '0;
      enc_b_sync <= '0;
    end else begin
      keys_meta  <= keys_n;
      keys_sync  <= keys_meta;
      enc_a_meta <= enc_a;
      enc_a_sync <= enc_a_meta;
      enc_b_meta <= enc_b;
      enc_b_sync <= enc_b_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             init_done_q, init_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_tick) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d     = ST_IDLE;
          idx_d       = '0;
          init_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_SCAN);

  // -------------------------------------------------------------------------
  // Per-channel state
  // -------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_state_q;           // committed state, 1 = pressed
  logic [3:0]          deb_cnt_q [NUM_KEYS];
  logic [1:0]          enc_prev_q [NUM_ENC];
  logic signed [3:0]   enc_sub_q [NUM_ENC];

  logic             scanning, is_key;
  logic [KEY_W-1:0] key_idx;
  logic [ENC_W-1:0] enc_idx;

  assign scanning = (state_q == ST_SCAN);
  assign is_key   = (idx_q < IDX_W'(NUM_KEYS));
  assign key_idx  = KEY_W'(idx_q);
  assign enc_idx  = ENC_W'(idx_q - IDX_W'(NUM_KEYS));

  logic              key_sample, key_cur, key_state_d;
  logic [3:0]        key_cnt_d;
  logic [1:0]        ab_cur;
  logic signed [3:0] step, sub_sum, sub_d;
  logic              push;
  logic [7:0]        push_code;

  always_comb begin
    key_sample  = ~keys_sync[key_idx];
    key_cur     = key_state_q[key_idx];
    key_state_d = key_cur;
    key_cnt_d   = deb_cnt_q[key_idx];
    ab_cur      = {enc_a_sync[enc_idx], enc_b_sync[enc_idx]};
    step        = gray_step(enc_prev_q[enc_idx], ab_cur);
    sub_sum     = enc_sub_q[enc_idx] + step;
    sub_d       = enc_sub_q[enc_idx];
    push        = 1'b0;
    push_code   = 8'h00;

    if (scanning) begin
      if (is_key) begin
        if (!init_done_q) begin
          // First scan after reset adopts the current level silently.
          key_state_d = key_sample;
          key_cnt_d   = 4'd0;
        end else if (key_sample == key_cur) begin
          key_cnt_d = 4'd0;
        end else if (deb_cnt_q[key_idx] == DEB_LAST) begin
          key_state_d = key_sample;
          key_cnt_d   = 4'd0;
          push        = 1'b1;
          push_code   = {1'b0, key_sample, 6'(idx_q)};
        end else begin
          key_cnt_d = deb_cnt_q[key_idx] + 4'd1;
        end
      end else if (init_done_q) begin
        if (sub_sum == STEP_POS) begin
          sub_d     = 4'sd0;
          push      = 1'b1;
          push_code = {2'b11, 6'(enc_idx)};
        end else if (sub_sum == STEP_NEG) begin
          sub_d     = 4'sd0;
          push      = 1'b1;
          push_code = {2'b10, 6'(enc_idx)};
        end else begin
          sub_d = sub_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) deb_cnt_q[i] <= '0;
      for (int i = 0; i < NUM_ENC; i++) begin
        enc_prev_q[i] <= 2'b00;
        enc_sub_q[i]  <= 4'sd0;
      end
    end else if (scanning) begin
      if (is_key) begin
        key_state_q[key_idx] <= key_state_d;
        deb_cnt_q[key_idx]   <= key_cnt_d;
      end else begin
        enc_prev_q[enc_idx] <= ab_cur;
        enc_sub_q[enc_idx]  <= sub_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // -------------------------------------------------------------------------
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              empty, full, do_pop, do_push, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = evt_if.evt_rd && !empty;
  // When full, a same-clock pop frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // NOTE: the storage array has no reset; only pointers and count do, and
  // the read port is masked while empty so stale contents never show.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A drop in the same clock as ovf_clr keeps the flag set.
      if (drop)                overflow_q <= 1'b1;
      else if (evt_if.ovf_clr) overflow_q <= 1'b0;
    end
  end

  assign evt_if.evt_data  = empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign evt_if.evt_valid = !empty;
  assign evt_if.evt_count = count_q;
  assign evt_if.overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_scanner.sv
// ---------------------------------------------------------------------------
// tb_key_event_scanner
//
// Directed bench for key_event_scanner with default parameters
// (32 keys, 4 encoders, debounce 4, 4 steps per event, 16-deep FIFO).
// Expected event codes and counts are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_key_event_scanner;

  localparam int NUM_KEYS = 32;
  localparam int NUM_ENC  = 4;
  localparam int DEPTH    = 16;
  localparam int NUM_CH   = NUM_KEYS + NUM_ENC;

  logic                clk = 1'b0;
  logic                rst;
  logic                scan_tick;
  logic [NUM_KEYS-1:0] keys_n;
  logic [NUM_ENC-1:0]  enc_a, enc_b;
  logic                busy;

  key_event_scanner_if #(.FIFO_DEPTH(DEPTH)) bus ();

  key_event_scanner #(
    .NUM_KEYS           (NUM_KEYS),
    .NUM_ENC            (NUM_ENC),
    .DEBOUNCE_TICKS     (4),
    .ENC_STEPS_PER_EVENT(4),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_tick(scan_tick),
    .keys_n   (keys_n),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .evt_if   (bus.master),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; return 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full scan. rd_idx >= 0 raises evt_rd for exactly the clock in which
  // channel rd_idx is processed.
  task automatic run_scan(input int rd_idx);
    bit done;
    tick(3);
    scan_tick = 1'b1;
    tick(1);
    scan_tick  = 1'b0;
    bus.evt_rd = (rd_idx == 0);
    done = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      tick(1);
      bus.evt_rd = (c == rd_idx);
      if (!busy) done = 1'b1;
    end
    bus.evt_rd = 1'b0;
    if (!done) check("scan_timeout", 32'(busy), 32'd0);
  endtask

  task automatic scans(input int n);
    repeat (n) run_scan(-1);
  endtask

  task automatic expect_count(input string tag, input int n);
    check(tag, 32'(bus.evt_count), 32'(n));
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] code);
    check({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.evt_data), 32'(code));
    bus.evt_rd = 1'b1;
    tick(1);
    bus.evt_rd = 1'b0;
  endtask

  task automatic set_ab2(input logic [1:0] ab);
    enc_a[2] = ab[1];
    enc_b[2] = ab[0];
    run_scan(-1);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    scan_tick   = 1'b0;
    keys_n      = '1;
    keys_n[3]   = 1'b0;
    enc_a       = '0;
    enc_b       = '0;
    bus.evt_rd  = 1'b0;
    bus.ovf_clr = 1'b0;
    tick(2);

    // Reset state
    check("rst_data",     32'(bus.evt_data),  32'h0);
    check("rst_valid",    32'(bus.evt_valid), 32'd0);
    check("rst_count",    32'(bus.evt_count), 32'd0);
    check("rst_overflow", 32'(bus.overflow),  32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    rst = 1'b0;

    // Init scan with key 3 held: silent
    run_scan(-1);
    expect_count("init_no_evt", 0);

    // Key 3 release then press
    keys_n[3] = 1'b1;
    scans(3);
    expect_count("k3_rel_early", 0);
    scans(1);
    expect_count("k3_rel_one", 1);
    pop_expect("k3_rel", 8'h03);
    expect_count("k3_rel_drained", 0);
    keys_n[3] = 1'b0;
    scans(3);
    expect_count("k3_prs_early", 0);
    scans(1);
    pop_expect("k3_prs", 8'h43);

    // Key 5 bounce: 3 low, 1 high, 4 low
    keys_n[5] = 1'b0;
    scans(3);
    keys_n[5] = 1'b1;
    scans(1);
    keys_n[5] = 1'b0;
    scans(3);
    expect_count("k5_bounce_early", 0);
    scans(1);
    expect_count("k5_one", 1);
    pop_expect("k5_prs", 8'h45);

    // Encoder 2 clockwise
    set_ab2(2'b01);
    set_ab2(2'b11);
    set_ab2(2'b10);
    expect_count("enc_cw_early", 0);
    set_ab2(2'b00);
    expect_count("enc_cw_one", 1);
    pop_expect("enc_cw", 8'hC2);

    // Encoder 2 counter-clockwise
    set_ab2(2'b10);
    set_ab2(2'b11);
    set_ab2(2'b01);
    expect_count("enc_ccw_early", 0);
    set_ab2(2'b00);
    pop_expect("enc_ccw", 8'h82);

    // Double-bit jump is ignored: 3 further CW steps stay silent, 4th fires
    set_ab2(2'b11);
    expect_count("enc_jump", 0);
    set_ab2(2'b10);
    set_ab2(2'b00);
    set_ab2(2'b01);
    expect_count("enc_jump_sub", 0);
    set_ab2(2'b11);
    pop_expect("enc_after_jump", 8'hC2);

    // Fill FIFO with 16 presses (keys 16..31)
    keys_n[31:16] = '0;
    scans(4);
    expect_count("fill_count", 16);
    check("fill_ovf",  32'(bus.overflow), 32'd0);
    check("fill_head", 32'(bus.evt_data), 32'h50);

    // 17th event (key 5 release) is dropped
    keys_n[5] = 1'b1;
    scans(4);
    expect_count("drop_count", 16);
    check("drop_ovf",  32'(bus.overflow), 32'd1);
    check("drop_head", 32'(bus.evt_data), 32'h50);

    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // Push (key 3 release) and pop in the same clock while full
    keys_n[3] = 1'b1;
    scans(3);
    expect_count("full_pre", 16);
    run_scan(3);
    expect_count("full_pushpop_count", 16);
    check("full_pushpop_ovf",  32'(bus.overflow), 32'd0);
    check("full_pushpop_head", 32'(bus.evt_data), 32'h51);

    for (int i = 1; i < 16; i++) pop_expect("drain", 8'(8'h50 + i));
    pop_expect("drain_last", 8'h03);
    expect_count("drained", 0);

    // Pop on empty
    bus.evt_rd = 1'b1;
    tick(1);
    bus.evt_rd = 1'b0;
    expect_count("empty_pop_count", 0);
    check("empty_pop_valid", 32'(bus.evt_valid), 32'd0);

    // scan_tick during SCAN ignored; busy lasts exactly NUM_CH clocks
    tick(3);
    scan_tick = 1'b1;
    tick(1);
    scan_tick = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      n++;
      scan_tick = (c == 5) || (c == NUM_CH - 1);
      tick(1);
    end
    scan_tick = 1'b0;
    check("busy_len", 32'(n), 32'(NUM_CH));
    tick(2);
    check("busy_stays_low", 32'(busy), 32'd0);
    expect_count("retick_no_evt", 0);

    // Queue 3 events, then reset at idx 10
    keys_n[2:0] = '0;
    scans(4);
    expect_count("pre_rst_count", 3);
    tick(3);
    scan_tick = 1'b1;
    tick(1);
    scan_tick = 1'b0;
    tick(10);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.evt_valid), 32'd0);
    check("midrst_busy",  32'(busy),          32'd0);
    check("midrst_count", 32'(bus.evt_count), 32'd0);
    tick(1);
    rst = 1'b0;

    run_scan(-1);
    expect_count("post_rst_init", 0);
    scans(4);
    expect_count("post_rst_no_evt", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
